// File: rtl/fp_mult_pkg.sv
// Shared types and widths for the fp_mult_sig client datapath.
// Holds the issue FSM encoding and the packed request record.
// Imported by the interface, the tag FIFO and the client top.
package fp_mult_pkg;

   localparam int FP_DATA_W = 32;
   localparam int FP_TAG_W  = 4;

   typedef enum logic {ST_IDLE, ST_SEND} issue_state_t;

   typedef struct packed {
      logic [FP_DATA_W-1:0] a;
      logic [FP_DATA_W-1:0] b;
      logic [FP_TAG_W-1:0]  tag;
   } mult_req_t;

endpackage

// File: rtl/fp_mult_client_if.sv
// Bundle of the requester, operand, result and response channels.
// The slave modport is the client's view; master is the surrounding logic
// (requester, multiplier and response consumer seen as one environment).
interface fp_mult_client_if
   import fp_mult_pkg::*;
#(
   parameter int DATA_W = FP_DATA_W,
   parameter int TAG_W  = FP_TAG_W
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic [TAG_W-1:0]  req_tag;

   logic              m_axis_a_tvalid;
   logic              m_axis_a_tready;
   logic [DATA_W-1:0] m_axis_a_tdata;
   logic              m_axis_b_tvalid;
   logic              m_axis_b_tready;
   logic [DATA_W-1:0] m_axis_b_tdata;

   logic              s_axis_result_tvalid;
   logic              s_axis_result_tready;
   logic [DATA_W-1:0] s_axis_result_tdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [TAG_W-1:0]  rsp_tag;

   modport slave (
      input  req_valid, req_a, req_b, req_tag,
      output req_ready,
      output m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata,
      input  m_axis_a_tready, m_axis_b_tready,
      input  s_axis_result_tvalid, s_axis_result_tdata,
      output s_axis_result_tready,
      output rsp_valid, rsp_data, rsp_tag,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_a, req_b, req_tag,
      input  req_ready,
      input  m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata,
      output m_axis_a_tready, m_axis_b_tready,
      output s_axis_result_tvalid, s_axis_result_tdata,
      input  s_axis_result_tready,
      input  rsp_valid, rsp_data, rsp_tag,
      output rsp_ready
   );

endinterface

// File: rtl/fp_tag_fifo.sv
// In-order tag FIFO tracking requests whose product has not come back yet.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty.
module fp_tag_fifo
   import fp_mult_pkg::*;
#(
   parameter int WIDTH = FP_TAG_W,
   parameter int DEPTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        push_dat_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        pop_dat_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Storage has no reset: an entry is only read after it has been written.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fp_mult_client.sv
// Tagged request front-end for fp_mult_sig: issues A/B operands, returns products in order.
// Latency: operands valid 1 cycle after accept; response valid 1 cycle after result handshake.
// Backpressure: req_ready low while sending or DEPTH in flight; result tready low only while a response is stalled.
module fp_mult_client
   import fp_mult_pkg::*;
#(
   parameter int DATA_W = FP_DATA_W,
   parameter int TAG_W  = FP_TAG_W,
   parameter int DEPTH  = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   fp_mult_client_if.slave        bus,
   output logic [$clog2(DEPTH):0] inflight,
   output logic                   err_orphan
);
   issue_state_t      state_q, state_d;
   logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
   logic [DATA_W-1:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;
   logic              rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic              orphan_q, orphan_d;

   mult_req_t         req_w;
   logic              req_rdy;
   logic              tag_push, tag_pop, tag_full, tag_empty;
   logic [TAG_W-1:0]  head_tag;
   logic              res_rdy, res_hs;

   assign req_w = '{a: bus.req_a, b: bus.req_b, tag: bus.req_tag};

   fp_tag_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .push_i     (tag_push),
      .push_dat_i (req_w.tag),
      .pop_i      (tag_pop),
      .pop_dat_o  (head_tag),
      .full_o     (tag_full),
      .empty_o    (tag_empty),
      .count_o    (inflight)
   );

   // Issue FSM: accept one request, then hold each operand until its own handshake.
   always_comb begin
      state_d  = state_q;
      a_vld_d  = a_vld_q;
      b_vld_d  = b_vld_q;
      a_dat_d  = a_dat_q;
      b_dat_d  = b_dat_q;
      req_rdy  = 1'b0;
      tag_push = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_rdy = !tag_full;
            if (bus.req_valid && !tag_full) begin
               a_dat_d  = req_w.a;
               b_dat_d  = req_w.b;
               a_vld_d  = 1'b1;
               b_vld_d  = 1'b1;
               tag_push = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.m_axis_a_tready) a_vld_d = 1'b0;
            if (bus.m_axis_b_tready) b_vld_d = 1'b0;
            if (!a_vld_d && !b_vld_d) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Issue-side registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         a_vld_q <= 1'b0;
         b_vld_q <= 1'b0;
         a_dat_q <= '0;
         b_dat_q <= '0;
      end else begin
         state_q <= state_d;
         a_vld_q <= a_vld_d;
         b_vld_q <= b_vld_d;
         a_dat_q <= a_dat_d;
         b_dat_q <= b_dat_d;
      end
   end

   // A result with no outstanding tag is always drained, so a stalled response never blocks it.
   assign res_rdy = !rsp_vld_q || bus.rsp_ready || tag_empty;
   assign res_hs  = bus.s_axis_result_tvalid && res_rdy;
   assign tag_pop = res_hs && !tag_empty;

   // Response register: a capture takes priority over the drain so back-to-back responses flow.
   always_comb begin
      rsp_vld_d = rsp_vld_q;
      rsp_dat_d = rsp_dat_q;
      rsp_tag_d = rsp_tag_q;
      orphan_d  = orphan_q;
      if (rsp_vld_q && bus.rsp_ready) rsp_vld_d = 1'b0;
      if (tag_pop) begin
         rsp_vld_d = 1'b1;
         rsp_dat_d = bus.s_axis_result_tdata;
         rsp_tag_d = head_tag;
      end
      if (res_hs && tag_empty) orphan_d = 1'b1;
   end

   // Result-side registers; err_orphan is cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
         rsp_tag_q <= '0;
         orphan_q  <= 1'b0;
      end else begin
         rsp_vld_q <= rsp_vld_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_tag_q <= rsp_tag_d;
         orphan_q  <= orphan_d;
      end
   end

   assign bus.req_ready            = req_rdy;
   assign bus.m_axis_a_tvalid      = a_vld_q;
   assign bus.m_axis_a_tdata       = a_dat_q;
   assign bus.m_axis_b_tvalid      = b_vld_q;
   assign bus.m_axis_b_tdata       = b_dat_q;
   assign bus.s_axis_result_tready = res_rdy;
   assign bus.rsp_valid            = rsp_vld_q;
   assign bus.rsp_data             = rsp_dat_q;
   assign bus.rsp_tag              = rsp_tag_q;
   assign err_orphan               = orphan_q;

endmodule
